ulbf_data_axis2ram_64b: RTL
===========================

# ulbf_data_axis2ram_64b

Capture stage downstream of the beamformer AXI4-Stream data path. Accepts 64-bit beats from the AI Engine PLIO output, writes them into an internal simple-dual-port RAM, and checks TLAST framing against the programmed block size. Host software reads the captured data back through a registered read port for comparison with golden vectors.

## Interface
- `RAM_DEPTH`, 2048: capture RAM depth in 64-bit words; power of two, at most 65536.
- `DATA_WIDTH`, 64: stream and RAM word width.
- `s_axis_clk` in 1: single clock for stream, control and read port.
- `s_axis_rst_n` in 1: reset, asynchronous assert, active-low.
- `s_axis_tvalid` in 1: upstream beat valid.
- `s_axis_tready` out 1: beat accepted when `tvalid && tready`.
- `s_axis_tdata` in DATA_WIDTH: beat payload.
- `s_axis_tlast` in 1: end-of-block marker from upstream.
- `s_axis_tkeep` in DATA_WIDTH/8: ignored; all bytes are written.
- `go` in 1: level start request.
- `niter` in 12: number of blocks to capture.
- `block_size` in 12: beats per block.
- `rollover_addr` in 16: last RAM address before the write address wraps to 0.
- `done` out 1: capture complete.
- `addr_wire` out 16: current write address.
- `tlast_err_cnt` out 16: count of framing errors; saturates at 0xFFFF.
- `rd_addr` in 16: host read address; only the low log2(RAM_DEPTH) bits are used.
- `rd_data` out DATA_WIDTH: RAM word at `rd_addr`, registered.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `tready`=0, `done`=0.
  - When `go`=1: latch `niter`, `block_size` and `rollover_addr`; clear the beat, block, address and error counters.
  - If the latched `niter`==0 or `block_size`==0, go to DONE. Otherwise go to RUN.
- **RUN**
  - `tready`=1. Each accepted beat writes `tdata` to RAM[`addr`].
  - Address update: if `addr`==eff_rollover, `addr` becomes 0; otherwise `addr` increments by 1.
  - eff_rollover = min(`rollover_addr`, RAM_DEPTH-1).
- **Beat and block counting (RUN)**
  - `beat_cnt` counts 0..block_size-1.
  - On the beat where `beat_cnt`==block_size-1:
    - If `tlast`=0, increment `tlast_err_cnt`.
    - Set `beat_cnt` to 0 and increment `blk_cnt`.
  - On any other beat, `tlast`=1 increments `tlast_err_cnt`.
  - Framing is never resynchronised to `tlast`; only the counters define block boundaries.
- **RUN exit**
  - When the final beat of block niter-1 is accepted, go to DONE. `tready` drops in the following cycle.
- **DONE**
  - `tready`=0, `done`=1.
  - Hold until `go`=0, then go to IDLE.
  - Counters and `tlast_err_cnt` hold their values until the next start.
- **Other rules**
  - A change of `go` during RUN is ignored; capture always runs to completion.
  - Parameter inputs are used only at the moment they are latched.
  - `addr_wire` always shows the address the next beat will be written to.
- **Reset** (async, including mid-capture)
  - Go to IDLE immediately.
  - All outputs and counters clear to 0: `tready`=0, `done`=0, `addr_wire`=0, `tlast_err_cnt`=0, `rd_data`=0.
  - RAM contents are not cleared.

## Timing
- `tready` is a registered output, never combinational from `tvalid`.
- Start latency: `go` sampled high at edge N gives `tready`=1 from edge N+1.
- Write latency: a beat accepted at edge N is visible at `rd_data` for `rd_addr`=that address after edge N+2.
- Read latency: exactly 1 cycle, `rd_addr` to `rd_data`.
- Same-address read/write in one cycle returns the old data (read-first).
- Stalls: `tvalid`=0 cycles insert bubbles with no state change. Throughput is 1 beat per cycle.
- `done` rises on the edge after the last accepted beat.
- `tlast_err_cnt` updates on the edge that accepts the offending beat.

## Structure
- Package `ulbf_data_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - width constants: `CNT_W`=12, `ADDR_W`=16, `ERR_W`=16.
- Sub-module `ulbf_data_sdp_ram`: parameterised simple dual-port RAM.
  - One write port and one registered read port, read-first.
  - Inferred as block RAM, with no init file.
- Top level contains the FSM, counters, rollover logic and error counter.

## Test plan
- **Basic capture:** `block_size`=4, `niter`=3, `rollover_addr`=0xFFFF, 12 beats with data 0..11 and `tlast` on every 4th beat, `tvalid` always high.
  - `done` goes high; `addr_wire`=12; `tlast_err_cnt`=0.
  - Readback of addresses 0..11 returns 0..11.
- **Rollover:** `rollover_addr`=5, `block_size`=8, `niter`=1.
  - Addresses 6 and 7 are untouched.
  - Beats 6 and 7 land at RAM[0] and RAM[1]; final `addr_wire`=2.
- **Framing errors:** `block_size`=4, `niter`=2; `tlast` missing at beat 3 and extra `tlast` at beat 5.
  - `tlast_err_cnt`=2; `done` still rises after 8 beats.
- **Backpressure and bubbles:** random 50% `tvalid`, 8 beats.
  - Data is identical to the no-bubble run; `tready` is never high in IDLE or DONE.
- **Degenerate start:** `niter`=0 with `go`=1.
  - `done`=1 within 1 cycle; no RAM write; `addr_wire`=0.
  - `go`=0 returns the block to IDLE.
- **Reset mid-run:** assert `s_axis_rst_n`=0 after 3 of 8 beats.
  - All outputs 0 immediately; `tready` stays 0 until reset is released.
  - A subsequent start captures normally from address 0.

Source files
------------

// File: rtl/ulbf_data_pkg.sv
// rtl/ulbf_data_pkg.sv - shared widths and FSM state type for the capture stage
package ulbf_data_pkg;

   localparam int CNT_W  = 12;
   localparam int ADDR_W = 16;
   localparam int ERR_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ulbf_data_axis2ram_64b_if.sv
// rtl/ulbf_data_axis2ram_64b_if.sv - AXI4-Stream beat bundle feeding the capture stage
interface ulbf_data_axis2ram_64b_if #(
   parameter int DATA_WIDTH = 64
);

   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic                    tlast;
   logic [DATA_WIDTH/8-1:0] tkeep;

   modport master (output tvalid, tdata, tlast, tkeep, input tready);
   modport slave  (input tvalid, tdata, tlast, tkeep, output tready);

endinterface

// File: rtl/ulbf_data_sdp_ram.sv
// rtl/ulbf_data_sdp_ram.sv - simple dual-port RAM, one write port, registered read-first read port
module ulbf_data_sdp_ram #(
   parameter int DEPTH = 2048,
   parameter int WIDTH = 64,
   parameter int AW    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Non-blocking write above means a same-cycle read sees the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ulbf_data_axis2ram_64b.sv
// rtl/ulbf_data_axis2ram_64b.sv - capture AXI-Stream beats into RAM and count TLAST framing errors
module ulbf_data_axis2ram_64b
   import ulbf_data_pkg::*;
#(
   parameter int RAM_DEPTH  = 2048,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  s_axis_clk,
   input  logic                  s_axis_rst_n,
   ulbf_data_axis2ram_64b_if.slave s_axis,
   input  logic                  go,
   input  logic [CNT_W-1:0]      niter,
   input  logic [CNT_W-1:0]      block_size,
   input  logic [ADDR_W-1:0]     rollover_addr,
   output logic                  done,
   output logic [ADDR_W-1:0]     addr_wire,
   output logic [ERR_W-1:0]      tlast_err_cnt,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int                AW       = $clog2(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(RAM_DEPTH - 1);

   state_e            state_q;
   logic              tready_q;
   logic              done_q;
   logic [CNT_W-1:0]  niter_q;
   logic [CNT_W-1:0]  bsize_q;
   logic [ADDR_W-1:0] roll_q;
   logic [CNT_W-1:0]  beat_cnt_q;
   logic [CNT_W-1:0]  blk_cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic [ERR_W-1:0]  err_q;
   logic [ERR_W-1:0]  err_d;
   logic              beat_fire;
   logic              last_beat;
   logic              last_blk;
   logic              err_hit;
   logic              unused_ok;

   assign beat_fire = (state_q == RUN) && s_axis.tvalid && tready_q;
   assign last_beat = (beat_cnt_q == bsize_q - 12'd1);
   assign last_blk  = (blk_cnt_q == niter_q - 12'd1);
   assign addr_d    = (addr_q == roll_q) ? '0 : addr_q + 16'd1;

   // Block boundaries come only from the beat counter; tlast is just checked against it.
   assign err_hit = last_beat ? !s_axis.tlast : s_axis.tlast;
   assign err_d   = (err_hit && (err_q != '1)) ? err_q + 16'd1 : err_q;

   always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
      if (!s_axis_rst_n) begin
         state_q    <= IDLE;
         tready_q   <= 1'b0;
         done_q     <= 1'b0;
         niter_q    <= '0;
         bsize_q    <= '0;
         roll_q     <= '0;
         beat_cnt_q <= '0;
         blk_cnt_q  <= '0;
         addr_q     <= '0;
         err_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (go) begin
                  niter_q    <= niter;
                  bsize_q    <= block_size;
                  roll_q     <= (rollover_addr > MAX_ADDR) ? MAX_ADDR : rollover_addr;
                  beat_cnt_q <= '0;
                  blk_cnt_q  <= '0;
                  addr_q     <= '0;
                  err_q      <= '0;
                  if ((niter == '0) || (block_size == '0)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= RUN;
                     tready_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (beat_fire) begin
                  addr_q <= addr_d;
                  err_q  <= err_d;
                  if (last_beat) begin
                     beat_cnt_q <= '0;
                     blk_cnt_q  <= blk_cnt_q + 12'd1;
                     if (last_blk) begin
                        state_q  <= DONE;
                        tready_q <= 1'b0;
                        done_q   <= 1'b1;
                     end
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 12'd1;
                  end
               end
            end
            DONE: begin
               if (!go) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               tready_q <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   ulbf_data_sdp_ram #(
      .DEPTH (RAM_DEPTH),
      .WIDTH (DATA_WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk     (s_axis_clk),
      .rst_n   (s_axis_rst_n),
      .we_i    (beat_fire),
      .waddr_i (addr_q[AW-1:0]),
      .wdata_i (s_axis.tdata),
      .raddr_i (rd_addr[AW-1:0]),
      .rdata_o (rd_data)
   );

   assign s_axis.tready = tready_q;
   assign done          = done_q;
   assign addr_wire     = addr_q;
   assign tlast_err_cnt = err_q;

   // tkeep is deliberately ignored and upper read-address bits are don't-care.
   assign unused_ok = ^{s_axis.tkeep, rd_addr};

endmodule
